// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared writeback-select, load-funct3 and writeback-state types.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    typedef enum logic [1:0] {
        WB_ALU      = 2'd0,
        WB_DATA_MEM = 2'd1,
        WB_PC_PLUS4 = 2'd2,
        WB_IMM      = 2'd3
    } wb_sel_t;

    localparam logic [2:0] c_F3_LB  = 3'b000;
    localparam logic [2:0] c_F3_LH  = 3'b001;
    localparam logic [2:0] c_F3_LW  = 3'b010;
    localparam logic [2:0] c_F3_LBU = 3'b100;
    localparam logic [2:0] c_F3_LHU = 3'b101;

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_t;

endpackage
`default_nettype wire

// File: rtl/writeback_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit_if
// Description : Request, memory-return and register-file bundle of the unit.
// Revision    : 1.0 - initial release
// ============================================================================
interface writeback_unit_if
    import cpu_pkg::*;
#(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
);
    logic                  in_valid;
    logic                  in_ready;
    wb_sel_t               wb_sel;
    logic                  reg_write;
    logic [REG_ADDR_W-1:0] rd_addr;
    logic [2:0]            load_funct3;
    logic [1:0]            byte_offset;
    logic [XLEN-1:0]       alu_data_out;
    logic [XLEN-1:0]       pc_plus4;
    logic [XLEN-1:0]       imm_data;
    logic                  dm_read_valid;
    logic [XLEN-1:0]       dm_read_data;
    logic                  rf_write_en;
    logic [REG_ADDR_W-1:0] rf_write_addr;
    logic [XLEN-1:0]       rf_write_data;
    logic                  stall;
    logic                  mem_timeout_err;

    modport master (
        output in_valid, wb_sel, reg_write, rd_addr, load_funct3, byte_offset,
               alu_data_out, pc_plus4, imm_data, dm_read_valid, dm_read_data,
        input  in_ready, rf_write_en, rf_write_addr, rf_write_data, stall,
               mem_timeout_err
    );

    modport slave (
        input  in_valid, wb_sel, reg_write, rd_addr, load_funct3, byte_offset,
               alu_data_out, pc_plus4, imm_data, dm_read_valid, dm_read_data,
        output in_ready, rf_write_en, rf_write_addr, rf_write_data, stall,
               mem_timeout_err
    );
endinterface
`default_nettype wire

// File: rtl/load_extract.sv
`default_nettype none
// ============================================================================
// Module      : load_extract
// Description : Byte/halfword/word selection with sign or zero extension.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extract
    import cpu_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [2:0]      funct3,
    input  logic [1:0]      offset,
    input  logic [XLEN-1:0] word,
    output logic [XLEN-1:0] result
);
    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = word[7:0];
        case (offset)
            2'd0:    w_byte = word[7:0];
            2'd1:    w_byte = word[15:8];
            2'd2:    w_byte = word[23:16];
            default: w_byte = word[31:24];
        endcase
    end

    // Halfword ignores offset[0]; misaligned halves are not split.
    assign w_half = offset[1] ? word[31:16] : word[15:0];

    always_comb begin
        result = word;
        case (funct3)
            c_F3_LB:  result = {{(XLEN-8){w_byte[7]}}, w_byte};
            c_F3_LH:  result = {{(XLEN-16){w_half[15]}}, w_half};
            c_F3_LBU: result = {{(XLEN-8){1'b0}}, w_byte};
            c_F3_LHU: result = {{(XLEN-16){1'b0}}, w_half};
            c_F3_LW:  result = word;
            default:  result = word;
        endcase
    end
endmodule
`default_nettype wire

// File: rtl/writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : writeback_unit
// Description : Selects the writeback source, waits for load data with a
//               timeout, and drives a registered register-file write port.
// Revision    : 1.0 - initial release
// ============================================================================
module writeback_unit
    import cpu_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             rst,
    writeback_unit_if.slave  bus
);
    localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);

    wb_state_t             r_state;
    wb_state_t             w_state_nxt;
    logic [7:0]            r_wait_cnt;
    logic [7:0]            w_wait_cnt_nxt;
    logic [7:0]            w_wait_inc;

    logic                  r_cap_we;
    logic [REG_ADDR_W-1:0] r_cap_rd;
    logic [2:0]            r_cap_f3;
    logic [1:0]            r_cap_off;

    logic                  w_capture;
    logic                  w_issue;
    logic                  w_issue_we;
    logic [REG_ADDR_W-1:0] w_issue_addr;
    logic [XLEN-1:0]       w_issue_data;
    logic                  w_timeout;

    logic [2:0]            w_ext_f3;
    logic [1:0]            w_ext_off;
    logic [XLEN-1:0]       w_load_data;

    logic                  r_wr_en;
    logic [REG_ADDR_W-1:0] r_wr_addr;
    logic [XLEN-1:0]       r_wr_data;
    logic                  r_err;

    // While waiting, the captured load fields steer extraction, not the live bus.
    assign w_ext_f3  = (r_state == ST_WAIT_MEM) ? r_cap_f3  : bus.load_funct3;
    assign w_ext_off = (r_state == ST_WAIT_MEM) ? r_cap_off : bus.byte_offset;

    load_extract #(
        .XLEN (XLEN)
    ) u_load_extract (
        .funct3 (w_ext_f3),
        .offset (w_ext_off),
        .word   (bus.dm_read_data),
        .result (w_load_data)
    );

    assign w_wait_inc = r_wait_cnt + 8'd1;

    always_comb begin
        w_state_nxt    = r_state;
        w_wait_cnt_nxt = r_wait_cnt;
        w_capture      = 1'b0;
        w_issue        = 1'b0;
        w_issue_we     = 1'b0;
        w_issue_addr   = bus.rd_addr;
        w_issue_data   = w_load_data;
        w_timeout      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    w_issue_we   = bus.reg_write;
                    w_issue_addr = bus.rd_addr;
                    case (bus.wb_sel)
                        WB_ALU:      w_issue_data = bus.alu_data_out;
                        WB_PC_PLUS4: w_issue_data = bus.pc_plus4;
                        WB_IMM:      w_issue_data = bus.imm_data;
                        default:     w_issue_data = w_load_data;
                    endcase
                    if ((bus.wb_sel != WB_DATA_MEM) || bus.dm_read_valid) begin
                        w_issue = 1'b1;
                    end else begin
                        w_capture      = 1'b1;
                        w_wait_cnt_nxt = 8'd0;
                        w_state_nxt    = ST_WAIT_MEM;
                    end
                end
            end
            ST_WAIT_MEM: begin
                w_issue_we   = r_cap_we;
                w_issue_addr = r_cap_rd;
                // Returning data wins over an expiring counter in the same cycle.
                if (bus.dm_read_valid) begin
                    w_issue     = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_wait_cnt_nxt = w_wait_inc;
                    if (w_wait_inc == c_TIMEOUT) begin
                        w_timeout   = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_wait_cnt <= 8'd0;
            r_cap_we   <= 1'b0;
            r_cap_rd   <= '0;
            r_cap_f3   <= 3'd0;
            r_cap_off  <= 2'd0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_cnt_nxt;
            r_wr_en    <= w_issue && w_issue_we && (w_issue_addr != '0);
            if (w_issue) begin
                r_wr_addr <= w_issue_addr;
                r_wr_data <= w_issue_data;
            end
            if (w_capture) begin
                r_cap_we  <= bus.reg_write;
                r_cap_rd  <= bus.rd_addr;
                r_cap_f3  <= bus.load_funct3;
                r_cap_off <= bus.byte_offset;
            end
            if (w_timeout) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready        = (r_state == ST_IDLE);
    assign bus.stall           = (r_state == ST_WAIT_MEM);
    assign bus.rf_write_en     = r_wr_en;
    assign bus.rf_write_addr   = r_wr_addr;
    assign bus.rf_write_data   = r_wr_data;
    assign bus.mem_timeout_err = r_err;
endmodule
`default_nettype wire

// File: tb/tb_writeback_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_writeback_unit
// Description : Directed and randomized requests against a transaction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_writeback_unit;
    import cpu_pkg::*;

    localparam int XLEN = 32;
    localparam int RAW  = 5;
    localparam int TMO  = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    writeback_unit_if #(.XLEN(XLEN), .REG_ADDR_W(RAW)) bus();

    writeback_unit #(
        .XLEN        (XLEN),
        .REG_ADDR_W  (RAW),
        .MEM_TIMEOUT (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    logic            model_err;
    logic [RAW-1:0]  model_addr;
    logic [XLEN-1:0] model_data;

    task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Reference load: shift the word down to the addressed lane, then extend.
    function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
        logic [31:0] b;
        logic [31:0] h;
        b = (w >> (8 * int'(off))) & 32'hFF;
        h = (w >> (16 * int'(off[1]))) & 32'hFFFF;
        case (f3)
            3'b000:  return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
            3'b001:  return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
            3'b100:  return b;
            3'b101:  return h;
            default: return w;
        endcase
    endfunction

    task automatic drive_junk();
        bus.wb_sel       = wb_sel_t'($urandom_range(0, 3));
        bus.reg_write    = 1'($urandom_range(0, 1));
        bus.rd_addr      = RAW'($urandom);
        bus.load_funct3  = 3'($urandom);
        bus.byte_offset  = 2'($urandom);
        bus.alu_data_out = $urandom;
        bus.pc_plus4     = $urandom;
        bus.imm_data     = $urandom;
        bus.dm_read_data = $urandom;
    endtask

    task automatic check_held(input string tag);
        check({tag, "_addr"}, 32'(bus.rf_write_addr), 32'(model_addr));
        check({tag, "_data"}, bus.rf_write_data, model_data);
        check({tag, "_err"}, 32'(bus.mem_timeout_err), 32'(model_err));
    endtask

    task automatic do_reset();
        bus.in_valid      = 1'b0;
        bus.dm_read_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("rst_en", 32'(bus.rf_write_en), 32'd0);
        check("rst_addr", 32'(bus.rf_write_addr), 32'd0);
        check("rst_data", bus.rf_write_data, 32'd0);
        check("rst_stall", 32'(bus.stall), 32'd0);
        check("rst_err", 32'(bus.mem_timeout_err), 32'd0);
        check("rst_ready", 32'(bus.in_ready), 32'd1);
        rst = 1'b0;
        model_err  = 1'b0;
        model_addr = '0;
        model_data = '0;
    endtask

    // lat = 0: data with the request; lat = n: data in the n-th wait cycle.
    task automatic run_req(input wb_sel_t sel, input bit rw, input logic [RAW-1:0] rd,
                           input logic [2:0] f3, input logic [1:0] off,
                           input logic [XLEN-1:0] val, input logic [XLEN-1:0] word, input int lat);
        logic [XLEN-1:0] exp_data;
        bit              wrote;
        @(negedge clk);
        check("ready_idle", 32'(bus.in_ready), 32'd1);
        check("stall_idle", 32'(bus.stall), 32'd0);
        drive_junk();
        bus.in_valid    = 1'b1;
        bus.wb_sel      = sel;
        bus.reg_write   = rw;
        bus.rd_addr     = rd;
        bus.load_funct3 = f3;
        bus.byte_offset = off;
        case (sel)
            WB_ALU:      bus.alu_data_out = val;
            WB_PC_PLUS4: bus.pc_plus4     = val;
            WB_IMM:      bus.imm_data     = val;
            default:     ;
        endcase
        if (sel == WB_DATA_MEM) begin
            exp_data          = ref_load(f3, off, word);
            bus.dm_read_valid = (lat == 0);
            if (lat == 0) bus.dm_read_data = word;
            wrote = (lat <= TMO);
        end else begin
            exp_data          = val;
            bus.dm_read_valid = 1'($urandom_range(0, 1));
            wrote = 1'b1;
        end
        @(negedge clk);
        bus.in_valid      = 1'b0;
        bus.dm_read_valid = 1'b0;
        drive_junk();
        if (sel == WB_DATA_MEM && lat != 0) begin
            for (int i = 1; i <= TMO; i++) begin
                check("stall_wait", 32'(bus.stall), 32'd1);
                check("ready_wait", 32'(bus.in_ready), 32'd0);
                check("no_write_wait", 32'(bus.rf_write_en), 32'd0);
                drive_junk();
                bus.in_valid      = 1'($urandom_range(0, 1));
                bus.dm_read_valid = (i == lat);
                if (i == lat) bus.dm_read_data = word;
                @(negedge clk);
                bus.in_valid      = 1'b0;
                bus.dm_read_valid = 1'b0;
                if (i == lat) break;
            end
        end
        if (wrote) begin
            model_addr = rd;
            model_data = exp_data;
            check("write_en", 32'(bus.rf_write_en), 32'(rw && (rd != '0)));
        end else begin
            model_err = 1'b1;
            check("timeout_no_write", 32'(bus.rf_write_en), 32'd0);
        end
        check_held("result");
        check("stall_done", 32'(bus.stall), 32'd0);
        // Idle cycle with a stray memory strobe that must be ignored.
        drive_junk();
        bus.dm_read_valid = 1'($urandom_range(0, 1));
        @(negedge clk);
        bus.dm_read_valid = 1'b0;
        check("single_pulse", 32'(bus.rf_write_en), 32'd0);
        check_held("hold");
    endtask

    initial begin
        bus.in_valid      = 1'b0;
        bus.dm_read_valid = 1'b0;
        drive_junk();
        model_err  = 1'b0;
        model_addr = '0;
        model_data = '0;
        do_reset();

        run_req(WB_ALU, 1'b1, 5'd5, 3'd0, 2'd0, 32'h1234_5678, 32'h0, 0);
        check("alu_const", bus.rf_write_data, 32'h1234_5678);
        run_req(WB_DATA_MEM, 1'b1, 5'd3, c_F3_LB, 2'd2, 32'h0, 32'h00F0_0000, 0);
        check("lb_const", bus.rf_write_data, 32'hFFFF_FFF0);
        run_req(WB_DATA_MEM, 1'b1, 5'd3, c_F3_LBU, 2'd2, 32'h0, 32'h00F0_0000, 0);
        check("lbu_const", bus.rf_write_data, 32'h0000_00F0);
        run_req(WB_DATA_MEM, 1'b1, 5'd7, c_F3_LH, 2'd2, 32'h0, 32'h8001_0000, 3);
        check("lh_wait_const", bus.rf_write_data, 32'hFFFF_8001);
        check("lh_wait_addr", 32'(bus.rf_write_addr), 32'd7);
        run_req(WB_PC_PLUS4, 1'b1, 5'd0, 3'd0, 2'd0, 32'h0000_1004, 32'h0, 0);
        run_req(WB_IMM, 1'b0, 5'd4, 3'd0, 2'd0, 32'hDEAD_BEEF, 32'h0, 0);
        run_req(WB_DATA_MEM, 1'b1, 5'd9, 3'b111, 2'd1, 32'h0, 32'hCAFE_F00D, TMO);
        check("last_cycle_no_err", 32'(bus.mem_timeout_err), 32'd0);
        run_req(WB_DATA_MEM, 1'b1, 5'd6, c_F3_LW, 2'd0, 32'h0, 32'h1111_2222, TMO + 5);
        check("timeout_err", 32'(bus.mem_timeout_err), 32'd1);
        run_req(WB_ALU, 1'b1, 5'd8, 3'd0, 2'd0, 32'h0BAD_F00D, 32'h0, 0);
        check("err_sticky", 32'(bus.mem_timeout_err), 32'd1);
        do_reset();

        // Reset in the middle of a pending load.
        @(negedge clk);
        drive_junk();
        bus.in_valid    = 1'b1;
        bus.wb_sel      = WB_DATA_MEM;
        bus.reg_write   = 1'b1;
        bus.rd_addr     = 5'd9;
        @(negedge clk);
        bus.in_valid    = 1'b0;
        check("mid_rst_stall", 32'(bus.stall), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        bus.dm_read_valid = 1'b1;
        check("post_rst_ready", 32'(bus.in_ready), 32'd1);
        check("post_rst_stall", 32'(bus.stall), 32'd0);
        @(negedge clk);
        bus.dm_read_valid = 1'b0;
        check("post_rst_no_write", 32'(bus.rf_write_en), 32'd0);
        check("post_rst_data", bus.rf_write_data, 32'd0);
        model_err  = 1'b0;
        model_addr = '0;
        model_data = '0;

        for (int n = 0; n < 200; n++) begin
            wb_sel_t         s;
            int              lat;
            logic [2:0]      f3;
            s   = wb_sel_t'($urandom_range(0, 3));
            f3  = 3'($urandom);
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(TMO - 1, TMO + 2) : $urandom_range(0, 4);
            run_req(s, 1'($urandom_range(0, 1)), RAW'($urandom), f3, 2'($urandom),
                    $urandom, $urandom, lat);
            if (n % 50 == 49) do_reset();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/writeback_unit.md
WRITEBACK_UNIT -- requirements
Module: writeback_unit

Interface
REQ-001 Parameter XLEN, default 32, datapath width; SHALL be a multiple of 8 and at least 32.
REQ-002 Parameter REG_ADDR_W, default 5, register-file address width.
REQ-003 Parameter MEM_TIMEOUT, default 15, maximum WAIT_MEM cycles before abort; range 1..255.
REQ-004 clk  in  1  sole clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, synchronous and active-high.
REQ-006 in_valid  in  1  writeback request present.
REQ-007 in_ready  out  1  unit can accept a request this cycle.
REQ-008 wb_sel  in  2  source select, type wb_sel_t: ALU=0, DATA_MEM=1, PC_PLUS4=2, IMM=3.
REQ-009 reg_write  in  1  request writes the register file.
REQ-010 rd_addr  in  REG_ADDR_W  destination register.
REQ-011 load_funct3  in  3  load type: LB=000, LH=001, LW=010, LBU=100, LHU=101.
REQ-012 byte_offset  in  2  load address bits [1:0].
REQ-013 alu_data_out, pc_plus4, imm_data  in  XLEN each  candidate sources.
REQ-014 dm_read_valid  in  1  dm_read_data valid this cycle.
REQ-015 dm_read_data  in  XLEN  raw aligned memory word.
REQ-016 rf_write_en  out  1  register-file write strobe, one cycle wide.
REQ-017 rf_write_addr  out  REG_ADDR_W;  rf_write_data  out  XLEN.
REQ-018 stall  out  1  high while in WAIT_MEM.
REQ-019 mem_timeout_err  out  1  sticky load-timeout flag.

Function
REQ-020 States SHALL be IDLE and WAIT_MEM; in_ready SHALL be 1 in IDLE, 0 in WAIT_MEM.
REQ-021 A request is accepted when in_valid and in_ready are both 1.
REQ-022 Accepted non-DATA_MEM request SHALL produce registered rf_write_* exactly 1 cycle later; data = alu_data_out, pc_plus4 or imm_data per wb_sel.
REQ-023 Accepted DATA_MEM request with dm_read_valid=1 in the same cycle SHALL complete like REQ-022, staying in IDLE.
REQ-024 Accepted DATA_MEM request with dm_read_valid=0 SHALL capture rd_addr, reg_write, load_funct3 and byte_offset, then enter WAIT_MEM.
REQ-025 In WAIT_MEM with dm_read_valid=1, write SHALL issue next cycle using captured fields, and the state SHALL return to IDLE; dm_read_valid in IDLE without an accepted DATA_MEM request SHALL be ignored.
REQ-026 Load extraction: LB/LBU select byte byte_offset; LH/LHU select halfword byte_offset[1] (bit 0 ignored); LW uses the full word. LB/LH sign-extend to XLEN; LBU/LHU zero-extend. Undefined funct3 SHALL be treated as LW.
REQ-027 rf_write_en SHALL be 0 when reg_write=0 or rd_addr=0; rf_write_addr/rf_write_data still update.
REQ-028 A wait counter SHALL clear on WAIT_MEM entry and increment each WAIT_MEM cycle without dm_read_valid.
REQ-029 When the counter reaches MEM_TIMEOUT, the unit SHALL set mem_timeout_err, return to IDLE, and issue no write; dm_read_valid in that same cycle SHALL take priority (write, no error).
REQ-030 mem_timeout_err SHALL remain 1 until rst.
REQ-031 rf_write_en SHALL never be high in two cycles for a single request.

Reset
REQ-032 On rst: state=IDLE, counter=0, and rf_write_en, rf_write_addr, rf_write_data, stall and mem_timeout_err all 0.
REQ-033 rst mid-WAIT_MEM SHALL discard the pending load with no write; in_ready SHALL be 1 in the first cycle after rst deasserts.

Structure
REQ-034 wb_sel_t, the funct3 load encodings and the state enum SHALL live in shared package cpu_pkg.
REQ-035 Load extraction SHALL be a combinational sub-module load_extract (inputs: funct3, offset, word; output: XLEN result).

Verification
REQ-036 ALU, rd=5, alu_data_out=0x1234_5678 -> next cycle rf_write_en=1, addr=5, data=0x1234_5678.
REQ-037 DATA_MEM LB, offset=2, same-cycle valid, word=0x00F0_0000 -> data=0xFFFF_FFF0; with LBU -> 0x0000_00F0.
REQ-038 DATA_MEM LH, rd=7, valid arrives 3 cycles later, word=0x8001_0000, offset=2 -> stall and in_ready=0 for 3 cycles, then write 0xFFFF_8001 to rd=7.
REQ-039 PC_PLUS4, rd=0, reg_write=1 -> rf_write_en stays 0.
REQ-040 DATA_MEM request, no valid for 15 cycles -> mem_timeout_err=1, no write, back to IDLE; stays set until rst.
REQ-041 rst asserted during WAIT_MEM, then valid supplied -> no write; in_ready=1 in the first cycle after rst deasserts.
